deteccion_soplo: RTL and testbench

Breath-detection front end for the spirometer. It takes raw ADC flow samples, acquires a zero-flow baseline, and detects the start and end of an exhalation. It delivers baseline-subtracted flow, a per-sample strobe and the 2-bit measurement state directly to the flow accumulator (Suma_flujo), mapped as follows:

- ovFlujo → ivDatos
- oCE → iCE
- ovStateMachine → ivStateMachine
- oClear → iReset

---
 rtl/deteccion_soplo.sv | 153 +++++++++++++++
 tb/tb_deteccion_soplo.sv | 287 ++++++++++++++++++++++++++++
 2 files changed

// File: rtl/deteccion_soplo.sv
`default_nettype none
// ============================================================================
// Module   : deteccion_soplo
// Brief    : Breath-detection front end. Acquires a zero-flow baseline,
//            subtracts it from each ADC sample (saturating at 0) and tracks
//            the exhalation state (IDLE/ESPERA/SOPLO/FIN) for the downstream
//            flow accumulator.
// Revision : 1.0 - initial release
// ============================================================================
module deteccion_soplo #(
    parameter int BASE_LOG2     = 4,
    parameter int UMBRAL_INICIO = 8,
    parameter int UMBRAL_FIN    = 4,
    parameter int MUESTRAS_FIN  = 16,
    parameter int TIEMPO_MAX    = 64
) (
    input  logic       iClk,
    input  logic       iReset_n,
    input  logic       iSampleValid,
    input  logic [7:0] ivMuestra,
    input  logic       iStart,
    output logic [7:0] ovFlujo,
    output logic       oCE,
    output logic [1:0] ovStateMachine,
    output logic       oClear,
    output logic       oFin
);

    localparam logic [1:0] c_IDLE   = 2'd0;
    localparam logic [1:0] c_ESPERA = 2'd1;
    localparam logic [1:0] c_SOPLO  = 2'd2;
    localparam logic [1:0] c_FIN    = 2'd3;

    localparam int c_SUM_W = 8 + BASE_LOG2;
    localparam int c_LOW_W = $clog2(MUESTRAS_FIN + 1);

    localparam logic [7:0]         c_umbralInicio = 8'(UMBRAL_INICIO);
    localparam logic [7:0]         c_umbralFin    = 8'(UMBRAL_FIN);
    localparam logic [11:0]        c_tiempoMax    = 12'(TIEMPO_MAX);
    localparam logic [c_LOW_W-1:0] c_muestrasFin  = c_LOW_W'(MUESTRAS_FIN);

    logic [1:0]           r_state;
    logic [c_SUM_W-1:0]   r_sum;
    logic [BASE_LOG2-1:0] r_calCount;
    logic                 r_calDone;
    logic [7:0]           r_base;
    logic [11:0]          r_tiempo;
    logic [c_LOW_W-1:0]   r_lowRun;

    logic [7:0]           w_flujo;
    logic [c_SUM_W-1:0]   w_sumNext;
    logic                 w_calLast;
    logic [11:0]          w_tiempoNext;
    logic [c_LOW_W-1:0]   w_lowNext;

    // Per-sample arithmetic: saturating corrected flow and next counter values
    always_comb begin
        w_flujo      = (ivMuestra > r_base) ? (ivMuestra - r_base) : 8'd0;
        w_sumNext    = r_sum + {{BASE_LOG2{1'b0}}, ivMuestra};
        w_calLast    = (r_calCount == {BASE_LOG2{1'b1}});
        w_tiempoNext = r_tiempo + 12'd1;
        w_lowNext    = (w_flujo < c_umbralFin) ? (r_lowRun + 1'b1) : '0;
    end

    // State machine, baseline acquisition and registered outputs
    always_ff @(posedge iClk or negedge iReset_n) begin
        if (!iReset_n) begin
            r_state        <= c_IDLE;
            r_sum          <= '0;
            r_calCount     <= '0;
            r_calDone      <= 1'b0;
            r_base         <= 8'd0;
            r_tiempo       <= 12'd0;
            r_lowRun       <= '0;
            ovFlujo        <= 8'd0;
            oCE            <= 1'b0;
            ovStateMachine <= 2'd0;
            oClear         <= 1'b0;
            oFin           <= 1'b0;
        end else begin
            oCE    <= 1'b0;
            oClear <= 1'b0;
            oFin   <= 1'b0;
            case (r_state)
                c_IDLE, c_FIN: begin
                    // A start wins over a coincident sample, which is dropped
                    if (iStart) begin
                        r_state        <= c_ESPERA;
                        ovStateMachine <= c_ESPERA;
                        oClear         <= 1'b1;
                        r_sum          <= '0;
                        r_calCount     <= '0;
                        r_calDone      <= 1'b0;
                        r_tiempo       <= 12'd0;
                        r_lowRun       <= '0;
                    end else if (iSampleValid && (r_state == c_FIN)) begin
                        oCE            <= 1'b1;
                        ovFlujo        <= 8'd0;
                        ovStateMachine <= c_FIN;
                    end
                end
                c_ESPERA: begin
                    if (iSampleValid) begin
                        oCE <= 1'b1;
                        if (!r_calDone) begin
                            r_sum          <= w_sumNext;
                            r_calCount     <= r_calCount + 1'b1;
                            ovFlujo        <= 8'd0;
                            ovStateMachine <= c_ESPERA;
                            if (w_calLast) begin
                                r_base    <= w_sumNext[c_SUM_W-1:BASE_LOG2];
                                r_calDone <= 1'b1;
                            end
                        end else begin
                            ovFlujo <= w_flujo;
                            if (w_flujo >= c_umbralInicio) begin
                                // Onset sample already counts as the first breath sample
                                r_state        <= c_SOPLO;
                                ovStateMachine <= c_SOPLO;
                                r_tiempo       <= 12'd1;
                                r_lowRun       <= '0;
                            end else if (w_tiempoNext >= c_tiempoMax) begin
                                r_state        <= c_IDLE;
                                ovStateMachine <= c_IDLE;
                            end else begin
                                r_tiempo       <= w_tiempoNext;
                                ovStateMachine <= c_ESPERA;
                            end
                        end
                    end
                end
                default: begin // c_SOPLO
                    if (iSampleValid) begin
                        oCE      <= 1'b1;
                        ovFlujo  <= w_flujo;
                        r_tiempo <= w_tiempoNext;
                        r_lowRun <= w_lowNext;
                        // Ending sample is tagged FIN so the accumulator skips it
                        if ((w_lowNext >= c_muestrasFin) || (w_tiempoNext >= c_tiempoMax)) begin
                            r_state        <= c_FIN;
                            ovStateMachine <= c_FIN;
                            oFin           <= 1'b1;
                        end else begin
                            ovStateMachine <= c_SOPLO;
                        end
                    end
                end
            endcase
        end
    end

endmodule
`default_nettype wire

// File: tb/tb_deteccion_soplo.sv
`default_nettype none
// ============================================================================
// Module   : tb_deteccion_soplo
// Brief    : Directed self-checking bench for deteccion_soplo, with a small
//            model of the downstream flow accumulator.
// Revision : 1.0 - initial release
// ============================================================================
module tb_deteccion_soplo;

    logic       iClk;
    logic       iReset_n;
    logic       iSampleValid;
    logic [7:0] ivMuestra;
    logic       iStart;
    logic [7:0] ovFlujo;
    logic       oCE;
    logic [1:0] ovStateMachine;
    logic       oClear;
    logic       oFin;

    int checks;
    int errors;
    int acc;
    int finCount;

    deteccion_soplo dut (
        .iClk           (iClk),
        .iReset_n       (iReset_n),
        .iSampleValid   (iSampleValid),
        .ivMuestra      (ivMuestra),
        .iStart         (iStart),
        .ovFlujo        (ovFlujo),
        .oCE            (oCE),
        .ovStateMachine (ovStateMachine),
        .oClear         (oClear),
        .oFin           (oFin)
    );

    initial iClk = 1'b0;
    always #5 iClk = ~iClk;

    // Downstream accumulator model: integrates samples tagged state 2
    always @(negedge iClk) begin
        if (oClear) acc = 0;
        if (oCE && (ovStateMachine == 2'd2)) acc = acc + int'(ovFlujo);
        if (oFin) finCount = finCount + 1;
    end

    initial begin
        #200000;
        $display("FAIL watchdog: simulation did not finish in time");
        $fatal(1);
    end

    task automatic send(input logic [7:0] v);
        @(negedge iClk);
        iSampleValid = 1'b1;
        ivMuestra    = v;
        @(posedge iClk);
        #1;
        iSampleValid = 1'b0;
    endtask

    task automatic pulse_start();
        @(negedge iClk);
        iStart = 1'b1;
        @(posedge iClk);
        #1;
        iStart = 1'b0;
    endtask

    task automatic calibrate(input logic [7:0] v);
        pulse_start();
        for (int i = 0; i < 16; i++) send(v);
    endtask

    task automatic test_reset();
        iReset_n = 1'b1;
        #2 iReset_n = 1'b0;
        repeat (2) @(posedge iClk);
        #1;
        checks++;
        if ({ovFlujo, oCE, ovStateMachine, oClear, oFin} !== 13'd0) begin
            errors++;
            $display("FAIL reset_outputs: got flujo=%0d ce=%0b st=%0d clr=%0b fin=%0b, want all 0",
                     ovFlujo, oCE, ovStateMachine, oClear, oFin);
        end
        @(negedge iClk);
        iReset_n = 1'b1;
        pulse_start();
        checks++;
        if (oClear !== 1'b1 || ovStateMachine !== 2'd1 || oCE !== 1'b0 || oFin !== 1'b0 || ovFlujo !== 8'd0) begin
            errors++;
            $display("FAIL start_clear: got clr=%0b st=%0d ce=%0b fin=%0b flujo=%0d, want clr=1 st=1 ce=0 fin=0 flujo=0",
                     oClear, ovStateMachine, oCE, oFin, ovFlujo);
        end
        @(posedge iClk); #1;
        checks++;
        if (oClear !== 1'b0) begin
            errors++;
            $display("FAIL clear_one_cycle: got clr=%0b, want 0", oClear);
        end
    endtask

    task automatic test_baseline();
        for (int i = 0; i < 16; i++) send(8'd20);
        checks++;
        if (oCE !== 1'b1 || ovFlujo !== 8'd0 || ovStateMachine !== 2'd1) begin
            errors++;
            $display("FAIL calib_sample: got ce=%0b flujo=%0d st=%0d, want ce=1 flujo=0 st=1", oCE, ovFlujo, ovStateMachine);
        end
        send(8'd19);
        checks++;
        if (ovFlujo !== 8'd0 || ovStateMachine !== 2'd1) begin
            errors++;
            $display("FAIL saturate_19: got flujo=%0d st=%0d, want flujo=0 st=1", ovFlujo, ovStateMachine);
        end
        send(8'd27);
        checks++;
        if (ovFlujo !== 8'd7 || ovStateMachine !== 2'd1) begin
            errors++;
            $display("FAIL below_onset_27: got flujo=%0d st=%0d, want flujo=7 st=1", ovFlujo, ovStateMachine);
        end
        send(8'd28);
        checks++;
        if (ovFlujo !== 8'd8 || ovStateMachine !== 2'd2 || oCE !== 1'b1) begin
            errors++;
            $display("FAIL onset_28: got flujo=%0d st=%0d ce=%0b, want flujo=8 st=2 ce=1", ovFlujo, ovStateMachine, oCE);
        end
    endtask

    task automatic test_guards();
        pulse_start();
        checks++;
        if (oClear !== 1'b0 || ovStateMachine !== 2'd2) begin
            errors++;
            $display("FAIL start_in_soplo: got clr=%0b st=%0d, want clr=0 st=2", oClear, ovStateMachine);
        end
        send(8'd60);
        @(negedge iClk);
        iReset_n = 1'b0;
        #1;
        checks++;
        if ({ovFlujo, oCE, ovStateMachine, oClear, oFin} !== 13'd0) begin
            errors++;
            $display("FAIL reset_mid_soplo: got flujo=%0d ce=%0b st=%0d clr=%0b fin=%0b, want all 0",
                     ovFlujo, oCE, ovStateMachine, oClear, oFin);
        end
        @(negedge iClk);
        iReset_n = 1'b1;
        send(8'd90);
        checks++;
        if (oCE !== 1'b0 || ovStateMachine !== 2'd0) begin
            errors++;
            $display("FAIL idle_ignores_sample: got ce=%0b st=%0d, want ce=0 st=0", oCE, ovStateMachine);
        end
    endtask

    task automatic test_normal_breath();
        int bad;
        calibrate(8'd20);
        send(8'd30);
        checks++;
        if (ovFlujo !== 8'd10 || ovStateMachine !== 2'd2) begin
            errors++;
            $display("FAIL normal_onset: got flujo=%0d st=%0d, want flujo=10 st=2", ovFlujo, ovStateMachine);
        end
        for (int i = 0; i < 10; i++) send(8'd60);
        bad = 0;
        for (int i = 0; i < 15; i++) begin
            send(8'd22);
            if (ovStateMachine !== 2'd2 || oFin !== 1'b0) bad++;
        end
        checks++;
        if (bad != 0) begin
            errors++;
            $display("FAIL normal_low_run: %0d of the first 15 low samples left SOPLO, want 0", bad);
        end
        send(8'd22);
        checks++;
        if (ovStateMachine !== 2'd3 || oFin !== 1'b1 || oCE !== 1'b1) begin
            errors++;
            $display("FAIL normal_end: got st=%0d fin=%0b ce=%0b, want st=3 fin=1 ce=1", ovStateMachine, oFin, oCE);
        end
        @(posedge iClk); #1;
        checks++;
        if (acc != 440) begin
            errors++;
            $display("FAIL normal_sum: got %0d, want 440", acc);
        end
        send(8'd50);
        checks++;
        if (oCE !== 1'b1 || ovFlujo !== 8'd0 || ovStateMachine !== 2'd3 || oFin !== 1'b0) begin
            errors++;
            $display("FAIL fin_sample: got ce=%0b flujo=%0d st=%0d fin=%0b, want ce=1 flujo=0 st=3 fin=0",
                     oCE, ovFlujo, ovStateMachine, oFin);
        end
    endtask

    task automatic test_back_to_back();
        // Start and sample together from FIN: start taken, sample dropped
        @(negedge iClk);
        iStart       = 1'b1;
        iSampleValid = 1'b1;
        ivMuestra    = 8'd99;
        @(posedge iClk); #1;
        iStart       = 1'b0;
        iSampleValid = 1'b0;
        checks++;
        if (oClear !== 1'b1 || ovStateMachine !== 2'd1 || oCE !== 1'b0) begin
            errors++;
            $display("FAIL restart_from_fin: got clr=%0b st=%0d ce=%0b, want clr=1 st=1 ce=0", oClear, ovStateMachine, oCE);
        end
    endtask

    task automatic test_timeout();
        int bad;
        for (int i = 0; i < 16; i++) send(8'd0);
        bad = 0;
        for (int i = 0; i < 63; i++) begin
            send(8'd255);
            if (ovStateMachine !== 2'd2 || ovFlujo !== 8'd255) bad++;
        end
        checks++;
        if (bad != 0) begin
            errors++;
            $display("FAIL timeout_soplo: %0d of 63 samples not st=2 flujo=255, want 0", bad);
        end
        send(8'd255);
        checks++;
        if (ovStateMachine !== 2'd3 || oFin !== 1'b1) begin
            errors++;
            $display("FAIL timeout_end: got st=%0d fin=%0b, want st=3 fin=1", ovStateMachine, oFin);
        end
        @(posedge iClk); #1;
        checks++;
        if (acc != 16065) begin
            errors++;
            $display("FAIL timeout_sum: got %0d, want 16065", acc);
        end
    endtask

    task automatic test_no_onset();
        int finBefore;
        calibrate(8'd20);
        finBefore = finCount;
        for (int i = 0; i < 63; i++) send(8'd25);
        checks++;
        if (ovStateMachine !== 2'd1 || ovFlujo !== 8'd5) begin
            errors++;
            $display("FAIL no_onset_wait: got st=%0d flujo=%0d, want st=1 flujo=5", ovStateMachine, ovFlujo);
        end
        send(8'd25);
        checks++;
        if (ovStateMachine !== 2'd0 || oCE !== 1'b1 || oFin !== 1'b0) begin
            errors++;
            $display("FAIL no_onset_idle: got st=%0d ce=%0b fin=%0b, want st=0 ce=1 fin=0", ovStateMachine, oCE, oFin);
        end
        @(posedge iClk); #1;
        checks++;
        if (finCount != finBefore) begin
            errors++;
            $display("FAIL no_onset_fin_count: got %0d fin pulses, want 0", finCount - finBefore);
        end
    endtask

    initial begin
        checks       = 0;
        errors       = 0;
        acc          = 0;
        finCount     = 0;
        iSampleValid = 1'b0;
        ivMuestra    = 8'd0;
        iStart       = 1'b0;
        test_reset();
        test_baseline();
        test_guards();
        test_normal_breath();
        test_back_to_back();
        test_timeout();
        test_no_onset();
        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
`default_nettype wire
